// File: rtl/gray_conv_pipe.sv
// Streaming, pipelined Gray<->binary converter with per-beat direction select.
// Gray->binary is resolved MSB-first, one chunk of result bits per register stage.
module gray_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    input  logic             src_rdy_i,
    output logic             dst_rdy_o,
    output logic [WIDTH-1:0] data_o,
    output logic             mode_o,
    output logic             src_rdy_o,
    input  logic             dst_rdy_i,
    output logic [4:0]       occupancy
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    logic [WIDTH-1:0] data_reg  [STAGES];
    logic             mode_reg  [STAGES];
    logic [STAGES-1:0] valid_reg;
    logic [STAGES:0]  ready;
    logic [WIDTH-1:0] conv_data [STAGES];
    logic             in_mode   [STAGES];
    logic             in_valid  [STAGES];
    logic [4:0]       occ_reg;
    logic             in_xfer;
    logic             out_xfer;

    // Bits above the chunk are already binary, bits below are still raw Gray,
    // so the carry into the chunk's MSB is simply the binary bit just above it.
    function automatic logic [WIDTH-1:0] resolve_chunk(input logic [WIDTH-1:0] w, input int s);
        logic [WIDTH-1:0] res;
        logic             c;
        int               hi;
        int               lo;
        res = w;
        c   = 1'b0;
        hi  = WIDTH - 1 - s * CHUNK;
        lo  = hi - CHUNK + 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                res[i] = w[i] ^ c;
            end
            c = res[i];
        end
        return res;
    endfunction

    always_comb begin
        ready[STAGES] = dst_rdy_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = ~valid_reg[k] | ready[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            if (gi == 0) begin : gen_first
                // Binary->Gray is complete after the first stage.
                assign in_mode[gi]   = mode_i;
                assign in_valid[gi]  = src_rdy_i;
                assign conv_data[gi] = mode_i ? (data_i ^ (data_i >> 1))
                                              : resolve_chunk(data_i, 0);
            end else begin : gen_rest
                assign in_mode[gi]   = mode_reg[gi-1];
                assign in_valid[gi]  = valid_reg[gi-1];
                assign conv_data[gi] = mode_reg[gi-1] ? data_reg[gi-1]
                                                      : resolve_chunk(data_reg[gi-1], gi);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset || clear) begin
                valid_reg[k] <= 1'b0;
                mode_reg[k]  <= 1'b0;
                data_reg[k]  <= '0;
            end else if (ready[k]) begin
                valid_reg[k] <= in_valid[k];
                mode_reg[k]  <= in_mode[k];
                data_reg[k]  <= conv_data[k];
            end
        end
    end

    assign in_xfer  = src_rdy_i & ready[0];
    assign out_xfer = valid_reg[STAGES-1] & dst_rdy_i;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            occ_reg <= 5'd0;
        end else if (in_xfer && !out_xfer) begin
            occ_reg <= occ_reg + 5'd1;
        end else if (out_xfer && !in_xfer) begin
            occ_reg <= occ_reg - 5'd1;
        end
    end

    assign dst_rdy_o = ready[0];
    assign data_o    = data_reg[STAGES-1];
    assign mode_o    = mode_reg[STAGES-1];
    assign src_rdy_o = valid_reg[STAGES-1];
    assign occupancy = occ_reg;

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Bench for gray_conv_pipe: directed vectors on an 8/3 pipe, random streams on
// several depths with a scoreboard, and a 64-bit round trip.
module tb_gray_conv_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] g2b(input logic [63:0] g);
        logic [63:0] b;
        for (int i = 0; i < 64; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [63:0] b2g(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    logic tie0;
    assign tie0 = 1'b0;

    // Main 8-bit, 3-stage instance for directed tests
    logic       rst, clr, m_i, s_i, dr_o, m_o, s_o, dr_i;
    logic [7:0] d_i, d_o;
    logic [4:0] occ;

    gray_conv_pipe #(.WIDTH(8), .STAGES(3)) u_dut (
        .clk(clk), .reset(rst), .clear(clr), .data_i(d_i), .mode_i(m_i),
        .src_rdy_i(s_i), .dst_rdy_o(dr_o), .data_o(d_o), .mode_o(m_o),
        .src_rdy_o(s_o), .dst_rdy_i(dr_i), .occupancy(occ)
    );

    // 64-bit, 5-stage instance for the round trip
    logic        rst_w, wm_i, ws_i, wdr_o, wm_o, ws_o, wdr_i;
    logic [63:0] wd_i, wd_o;
    logic [4:0]  wocc;

    gray_conv_pipe #(.WIDTH(64), .STAGES(5)) u_wide (
        .clk(clk), .reset(rst_w), .clear(tie0), .data_i(wd_i), .mode_i(wm_i),
        .src_rdy_i(ws_i), .dst_rdy_o(wdr_o), .data_o(wd_o), .mode_o(wm_o),
        .src_rdy_o(ws_o), .dst_rdy_i(wdr_i), .occupancy(wocc)
    );

    // Random streaming instances, all 512 words each, scoreboard checked
    logic rst_x;
    logic ex_start = 1'b0;

    for (genvar gi = 0; gi < 4; gi++) begin : gen_x
        localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 8;
        logic [7:0] xd_i, xd_o;
        logic       xm_i, xm_o, xs_i, xdr_o, xs_o, xdr_i;
        logic [4:0] xocc;
        logic       done = 1'b0;

        gray_conv_pipe #(.WIDTH(8), .STAGES(ST)) u_x (
            .clk(clk), .reset(rst_x), .clear(tie0), .data_i(xd_i), .mode_i(xm_i),
            .src_rdy_i(xs_i), .dst_rdy_o(xdr_o), .data_o(xd_o), .mode_o(xm_o),
            .src_rdy_o(xs_o), .dst_rdy_i(xdr_i), .occupancy(xocc)
        );

        initial begin
            logic [8:0] exp_q[$];
            logic [8:0] held;
            logic [8:0] nxt;
            logic       stall_prev, in_x, out_x;
            int         sent, got;
            xs_i = 1'b0; xdr_i = 1'b0; xd_i = '0; xm_i = 1'b0;
            sent = 0; got = 0; stall_prev = 1'b0; held = '0;
            wait (ex_start);
            for (int cyc = 0; cyc < 8000 && got < 512; cyc++) begin
                @(posedge clk); #1;
                if (stall_prev) chk($sformatf("x%0d_stable", ST), {xs_o, xm_o, xd_o}, {1'b1, held});
                xs_i  = (sent < 512) && ($urandom_range(0, 3) != 0);
                xdr_i = ($urandom_range(0, 2) != 0);
                xd_i  = xs_i ? sent[7:0] : 8'($urandom);
                xm_i  = xs_i ? sent[8] : 1'($urandom);
                #1;
                in_x  = xs_i & xdr_o;
                out_x = xs_o & xdr_i;
                if (in_x) begin
                    nxt[8]   = sent[8];
                    nxt[7:0] = sent[8] ? 8'(b2g(64'(sent[7:0]))) : 8'(g2b(64'(sent[7:0])));
                    exp_q.push_back(nxt);
                    sent++;
                end
                if (out_x) begin
                    if (exp_q.size() == 0) chk($sformatf("x%0d_extra", ST), {xm_o, xd_o}, 64'h1ff00);
                    else chk($sformatf("x%0d_out", ST), {xm_o, xd_o}, exp_q.pop_front());
                    got++;
                end
                stall_prev = xs_o & ~xdr_i;
                held = {xm_o, xd_o};
            end
            chk($sformatf("x%0d_count", ST), 64'(got), 64'd512);
            xs_i = 1'b0; xdr_i = 1'b1;
            repeat (ST + 3) begin
                @(posedge clk); #1;
                chk($sformatf("x%0d_drain", ST), 64'(xs_o), 64'd0);
            end
            done = 1'b1;
        end
    end

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        vecs[8];
        int          n, cnt;
        logic [63:0] w, g;
        logic [63:0] words[6];

        vecs[0] = '{8'hCA, 1'b0, 8'h8C};
        vecs[1] = '{8'h00, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b0, 8'hAA};
        vecs[3] = '{8'h00, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 8'h80};
        vecs[5] = '{8'h80, 1'b0, 8'hFF};
        vecs[6] = '{8'h55, 1'b1, 8'h7F};
        vecs[7] = '{8'hA5, 1'b0, 8'hC6};

        rst = 1'b1; clr = 1'b0; d_i = '0; m_i = 1'b0; s_i = 1'b0; dr_i = 1'b0;
        rst_w = 1'b1; wd_i = '0; wm_i = 1'b0; ws_i = 1'b0; wdr_i = 1'b0;
        rst_x = 1'b1;
        repeat (2) tick();
        chk("rst_src_rdy", 64'(s_o), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_data", 64'(d_o), 64'd0);
        chk("rst_mode", 64'(m_o), 64'd0);
        rst = 1'b0; rst_w = 1'b0; rst_x = 1'b0;

        // Single words: latency, value, mode, one-cycle pulse
        dr_i = 1'b1;
        for (int v = 0; v < 8; v++) begin
            s_i = 1'b1; d_i = vecs[v].din; m_i = vecs[v].mode;
            tick();
            s_i = 1'b0; d_i = 8'h3C;
            n = 1;
            while (!s_o && n < 12) begin tick(); n++; end
            chk($sformatf("vec%0d_lat", v), 64'(n), 64'd3);
            chk($sformatf("vec%0d_data", v), 64'(d_o), 64'(vecs[v].exp));
            chk($sformatf("vec%0d_mode", v), 64'(m_o), 64'(vecs[v].mode));
            tick();
            chk($sformatf("vec%0d_pulse", v), 64'(s_o), 64'd0);
        end

        // Back-to-back mixed modes, no bubble
        s_i = 1'b1; d_i = 8'hFF; m_i = 1'b1; tick();
        d_i = 8'h80; m_i = 1'b0; tick();
        s_i = 1'b0; tick();
        chk("mix0", {s_o, m_o, d_o}, {1'b1, 1'b1, 8'h80});
        tick();
        chk("mix1", {s_o, m_o, d_o}, {1'b1, 1'b0, 8'hFF});
        tick();
        chk("mix_end", 64'(s_o), 64'd0);

        // Backpressure fill and release
        dr_i = 1'b0; m_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s_i = 1'b1; d_i = 8'(k); tick();
        end
        s_i = 1'b0; #1;
        chk("bp_occ", 64'(occ), 64'd3);
        chk("bp_dst_rdy", 64'(dr_o), 64'd0);
        chk("bp_head", {s_o, d_o}, {1'b1, 8'h01});
        tick();
        chk("bp_hold", {s_o, d_o}, {1'b1, 8'h01});
        dr_i = 1'b1; #1;
        chk("bp_release_rdy", 64'(dr_o), 64'd1);
        tick();
        chk("bp_out1", {s_o, d_o}, {1'b1, 8'h03});
        tick();
        chk("bp_out2", {s_o, d_o}, {1'b1, 8'h02});
        tick();
        chk("bp_empty", {s_o, occ}, 64'd0);

        // Reset, then clear with a simultaneous input, both with 2 words in flight
        for (int pass = 0; pass < 2; pass++) begin
            s_i = 1'b1; m_i = 1'b0; d_i = 8'h11; tick();
            d_i = 8'h22; tick();
            chk($sformatf("flush%0d_inflight", pass), 64'(occ), 64'd2);
            if (pass == 0) begin rst = 1'b1; s_i = 1'b0; end
            else begin clr = 1'b1; s_i = 1'b1; d_i = 8'h33; end
            tick();
            rst = 1'b0; clr = 1'b0; s_i = 1'b0;
            chk($sformatf("flush%0d_state", pass), {s_o, occ}, 64'd0);
            cnt = 0;
            repeat (6) begin tick(); if (s_o) cnt++; end
            chk($sformatf("flush%0d_none", pass), 64'(cnt), 64'd0);
        end

        // 64-bit round trip through both directions
        words[0] = '0;
        words[1] = '1;
        for (int k = 2; k < 6; k++) words[k] = {$urandom, $urandom};
        wdr_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = words[k];
            g = '0;
            for (int p = 0; p < 2; p++) begin
                ws_i = 1'b1; wd_i = (p == 0) ? w : g; wm_i = (p == 0);
                tick();
                ws_i = 1'b0; wd_i = '0;
                n = 1;
                while (!ws_o && n < 20) begin tick(); n++; end
                chk($sformatf("wide%0d_lat%0d", k, p), 64'(n), 64'd5);
                if (p == 0) begin
                    chk($sformatf("wide%0d_b2g", k), wd_o, w ^ (w >> 1));
                    g = wd_o;
                end else begin
                    chk($sformatf("wide%0d_trip", k), wd_o, w);
                end
                tick();
            end
        end

        // Random streams on STAGES 1,2,3,8
        ex_start = 1'b1;
        n = 0;
        while (!(gen_x[0].done && gen_x[1].done && gen_x[2].done && gen_x[3].done) && n < 20000) begin
            @(posedge clk); n++;
        end
        if (n >= 20000) chk("x_timeout", 64'd0, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
